multi_port_register_file: RTL and testbench

- Parametrised successor to the 8x8 single-write register file.
- Depth is 2**ADDRESS_WIDTH and width is BUS_WIDTH.
- Provides two read ports, two write ports with fixed priority, optional write-to-read bypass, optional hardwired zero register, per-register pending (scoreboard) bits, and a multi-cycle clear sweep.
- Sits between decode (reserve and read) and writeback (write) in the MCU datapath.

---
 rtl/multi_port_register_file_pkg.sv | 19 +
 rtl/multi_port_register_file_clear_sequencer.sv | 65 ++++++
 rtl/multi_port_register_file.sv | 136 +++++++++++++
 tb/tb_multi_port_register_file.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_port_register_file_pkg.sv
// Shared definitions for the multi-port register file and its clear sequencer.
// Contents: clear-sequencer state encoding, depth helper, and default values
// for the BYPASS and ZERO_REG build options.
package rf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } seq_state_e;

    localparam int DEFAULT_BYPASS   = 1;
    localparam int DEFAULT_ZERO_REG = 0;

    // Number of registers addressable with the given address width.
    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/multi_port_register_file_clear_sequencer.sv
// Clear sequencer: walks a counter over every register address after a
// clr_req pulse so the parent can zero one register per cycle.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   clr_req     - single-cycle pulse that starts a sweep (ignored while sweeping)
//   busy        - high for the whole sweep (exactly DEPTH cycles)
//   sweep_en    - parent should clear register sweep_addr this cycle
//   sweep_addr  - register being cleared this cycle
module clear_sequencer
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     sweep_en,
    output logic [ADDRESS_WIDTH-1:0] sweep_addr
);

    seq_state_e               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                // The last address is cleared on the same edge that returns to IDLE.
                if (cnt_q == {ADDRESS_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDRESS_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy       = (state_q == SWEEP);
    assign sweep_en   = busy;
    assign sweep_addr = cnt_q;

endmodule

// File: rtl/multi_port_register_file.sv
// Multi-port register file: 2**ADDRESS_WIDTH registers of BUS_WIDTH bits with
// two combinational read ports, two write ports (port 1 wins on collision),
// per-register pending bits, optional write-to-read bypass, optional hardwired
// zero register and a multi-cycle clear sweep.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   addrA/addrB -> Data_A/Data_B   - read ports (combinational)
//   pend_A/pend_B                  - pending bit of the addressed register
//   wr0_*/wr1_*                    - write ports, port 1 has priority
//   rsv_en/rsv_addr                - mark a register as pending
//   clr_req -> busy                - start / track the clear sweep
module multi_port_register_file
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 3,
    parameter int BUS_WIDTH     = 8,
    parameter int BYPASS        = DEFAULT_BYPASS,
    parameter int ZERO_REG      = DEFAULT_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] addrA,
    input  logic [ADDRESS_WIDTH-1:0] addrB,
    output logic [BUS_WIDTH-1:0]     Data_A,
    output logic [BUS_WIDTH-1:0]     Data_B,
    output logic                     pend_A,
    output logic                     pend_B,
    input  logic                     wr0_en,
    input  logic [ADDRESS_WIDTH-1:0] wr0_addr,
    input  logic [BUS_WIDTH-1:0]     wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDRESS_WIDTH-1:0] wr1_addr,
    input  logic [BUS_WIDTH-1:0]     wr1_data,
    input  logic                     rsv_en,
    input  logic [ADDRESS_WIDTH-1:0] rsv_addr,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int DEPTH = rf_depth(ADDRESS_WIDTH);

    logic [BUS_WIDTH-1:0]     mem_q [DEPTH];
    logic [BUS_WIDTH-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0]         pend_q, pend_d;
    logic                     sweep_en;
    logic [ADDRESS_WIDTH-1:0] sweep_addr;
    logic                     wr0_ok, wr1_ok, rsv_ok;

    clear_sequencer #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .busy      (busy),
        .sweep_en  (sweep_en),
        .sweep_addr(sweep_addr)
    );

    // Accepted operations: blocked during a sweep, and register 0 is immutable
    // when it is hardwired to zero.
    assign wr0_ok = wr0_en && !busy && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign wr1_ok = wr1_en && !busy && !((ZERO_REG != 0) && (wr1_addr == '0));
    assign rsv_ok = rsv_en && !busy && !((ZERO_REG != 0) && (rsv_addr == '0));

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (sweep_en) begin
            mem_d[sweep_addr]  = '0;
            pend_d[sweep_addr] = 1'b0;
        end else begin
            // Port 1 is applied last so it overrides port 0 on the same address.
            if (wr0_ok) begin
                mem_d[wr0_addr]  = wr0_data;
                pend_d[wr0_addr] = 1'b0;
            end
            if (wr1_ok) begin
                mem_d[wr1_addr]  = wr1_data;
                pend_d[wr1_addr] = 1'b0;
            end
            // Reserve is applied after the write clears so it wins a collision.
            if (rsv_ok) begin
                pend_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    logic [ADDRESS_WIDTH-1:0] rd_addr [2];
    assign rd_addr[0] = addrA;
    assign rd_addr[1] = addrB;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [BUS_WIDTH-1:0] data;
            logic                 pend;
            logic                 zero_hit;

            assign zero_hit = (ZERO_REG != 0) && (rd_addr[gi] == '0);

            // wrN_ok is already false while busy, so bypass is off during a sweep.
            always_comb begin
                data = zero_hit ? '0 : mem_q[rd_addr[gi]];
                pend = pend_q[rd_addr[gi]];
                if (BYPASS != 0) begin
                    if (wr1_ok && (wr1_addr == rd_addr[gi])) begin
                        data = wr1_data;
                        pend = 1'b0;
                    end else if (wr0_ok && (wr0_addr == rd_addr[gi])) begin
                        data = wr0_data;
                        pend = 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign Data_A = g_rd[0].data;
    assign Data_B = g_rd[1].data;
    assign pend_A = g_rd[0].pend;
    assign pend_B = g_rd[1].pend;

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench: a default instance (BYPASS=1, ZERO_REG=0) and a variant
// (BYPASS=0, ZERO_REG=1) share one stimulus stream; each vector lists the
// expected outputs for both.
module tb_multi_port_register_file;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] addrA, addrB;
    logic       wr0_en, wr1_en, rsv_en, clr_req;
    logic [2:0] wr0_addr, wr1_addr, rsv_addr;
    logic [7:0] wr0_data, wr1_data;

    logic [7:0] Data_A, Data_B, zData_A, zData_B;
    logic       pend_A, pend_B, zpend_A, zpend_B;
    logic       busy, zbusy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_port_register_file #(
        .ADDRESS_WIDTH(3), .BUS_WIDTH(8), .BYPASS(1), .ZERO_REG(0)
    ) dut (
        .clk(clk), .rst(rst), .addrA(addrA), .addrB(addrB),
        .Data_A(Data_A), .Data_B(Data_B), .pend_A(pend_A), .pend_B(pend_B),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .busy(busy)
    );

    multi_port_register_file #(
        .ADDRESS_WIDTH(3), .BUS_WIDTH(8), .BYPASS(0), .ZERO_REG(1)
    ) dut_z (
        .clk(clk), .rst(rst), .addrA(addrA), .addrB(addrB),
        .Data_A(zData_A), .Data_B(zData_B), .pend_A(zpend_A), .pend_B(zpend_B),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .busy(zbusy)
    );

    typedef struct {
        logic       w0e; logic [2:0] w0a; logic [7:0] w0d;
        logic       w1e; logic [2:0] w1a; logic [7:0] w1d;
        logic       re;  logic [2:0] ra;
        logic [2:0] aa;  logic [2:0] ab;
        logic [7:0] eda; logic epa; logic [7:0] edb; logic epb;
        logic [7:0] zda; logic zpa; logic [7:0] zdb; logic zpb;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_en = 1'b0; wr0_addr = 3'd0; wr0_data = 8'h00;
        wr1_en = 1'b0; wr1_addr = 3'd0; wr1_data = 8'h00;
        rsv_en = 1'b0; rsv_addr = 3'd0; clr_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            addrA = 3'(a);
            addrB = 3'(7 - a);
            @(negedge clk);
            chk({tag, " Data_A"}, Data_A, 8'h00);
            chk({tag, " Data_B"}, Data_B, 8'h00);
            chk({tag, " pend_A"}, {7'd0, pend_A}, 8'h00);
            chk({tag, " pend_B"}, {7'd0, pend_B}, 8'h00);
            chk({tag, " zData_A"}, zData_A, 8'h00);
            chk({tag, " zpend_A"}, {7'd0, zpend_A}, 8'h00);
            $display("%s: addr %0d A=%h/%b B=%h/%b", tag, a, Data_A, pend_A, Data_B, pend_B);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;

        //          w0e  w0a   w0d    w1e  w1a   w1d    re   ra    aa    ab    eda   epa   edb   epb   zda   zpa   zdb   zpb
        vecs[0]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd0,3'd7, 8'h00,1'b0,8'h00,1'b0, 8'h00,1'b0,8'h00,1'b0};
        vecs[1]  = '{1'b1,3'd3,8'h11, 1'b1,3'd3,8'h22, 1'b0,3'd0, 3'd3,3'd3, 8'h22,1'b0,8'h22,1'b0, 8'h00,1'b0,8'h00,1'b0};
        vecs[2]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd3,3'd5, 8'h22,1'b0,8'h00,1'b0, 8'h22,1'b0,8'h00,1'b0};
        vecs[3]  = '{1'b1,3'd5,8'hA5, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd3,3'd5, 8'h22,1'b0,8'hA5,1'b0, 8'h22,1'b0,8'h00,1'b0};
        vecs[4]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd5,3'd5, 8'hA5,1'b0,8'hA5,1'b0, 8'hA5,1'b0,8'hA5,1'b0};
        vecs[5]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b1,3'd2, 3'd2,3'd5, 8'h00,1'b0,8'hA5,1'b0, 8'h00,1'b0,8'hA5,1'b0};
        vecs[6]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd2,3'd3, 8'h00,1'b1,8'h22,1'b0, 8'h00,1'b1,8'h22,1'b0};
        vecs[7]  = '{1'b1,3'd2,8'h7E, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd2,3'd2, 8'h7E,1'b0,8'h7E,1'b0, 8'h00,1'b1,8'h00,1'b1};
        vecs[8]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd2,3'd2, 8'h7E,1'b0,8'h7E,1'b0, 8'h7E,1'b0,8'h7E,1'b0};
        vecs[9]  = '{1'b0,3'd0,8'h00, 1'b1,3'd2,8'h33, 1'b1,3'd2, 3'd2,3'd3, 8'h33,1'b0,8'h22,1'b0, 8'h7E,1'b0,8'h22,1'b0};
        vecs[10] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd2,3'd3, 8'h33,1'b1,8'h22,1'b0, 8'h33,1'b1,8'h22,1'b0};
        vecs[11] = '{1'b1,3'd0,8'h55, 1'b0,3'd0,8'h00, 1'b1,3'd0, 3'd0,3'd0, 8'h55,1'b0,8'h55,1'b0, 8'h00,1'b0,8'h00,1'b0};
        vecs[12] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 1'b0,3'd0, 3'd0,3'd1, 8'h55,1'b1,8'h00,1'b0, 8'h00,1'b0,8'h00,1'b0};

        rst = 1'b1;
        addrA = 3'd0;
        addrB = 3'd0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("reset busy", {7'd0, busy}, 8'h00);
        chk("reset zbusy", {7'd0, zbusy}, 8'h00);
        tick();
        check_all_zero("reset");

        // Table-driven vectors: outputs checked before the edge that commits them.
        for (int v = 0; v < NV; v++) begin
            wr0_en = vecs[v].w0e; wr0_addr = vecs[v].w0a; wr0_data = vecs[v].w0d;
            wr1_en = vecs[v].w1e; wr1_addr = vecs[v].w1a; wr1_data = vecs[v].w1d;
            rsv_en = vecs[v].re;  rsv_addr = vecs[v].ra;
            addrA  = vecs[v].aa;  addrB    = vecs[v].ab;
            @(negedge clk);
            chk($sformatf("vec%0d Data_A", v), Data_A, vecs[v].eda);
            chk($sformatf("vec%0d pend_A", v), {7'd0, pend_A}, {7'd0, vecs[v].epa});
            chk($sformatf("vec%0d Data_B", v), Data_B, vecs[v].edb);
            chk($sformatf("vec%0d pend_B", v), {7'd0, pend_B}, {7'd0, vecs[v].epb});
            chk($sformatf("vec%0d zData_A", v), zData_A, vecs[v].zda);
            chk($sformatf("vec%0d zpend_A", v), {7'd0, zpend_A}, {7'd0, vecs[v].zpa});
            chk($sformatf("vec%0d zData_B", v), zData_B, vecs[v].zdb);
            chk($sformatf("vec%0d zpend_B", v), {7'd0, zpend_B}, {7'd0, vecs[v].zpb});
            $display("vec%0d: A=%h/%b B=%h/%b zA=%h/%b zB=%h/%b", v, Data_A, pend_A,
                     Data_B, pend_B, zData_A, zpend_A, zData_B, zpend_B);
            tick();
        end
        idle_inputs();

        // Fill every register with 0xFF.
        for (int a = 0; a < 8; a++) begin
            wr0_en = 1'b1; wr0_addr = 3'(a); wr0_data = 8'hFF;
            tick();
        end
        idle_inputs();

        // First sweep: count busy cycles, probe unswept data, drop a mid-sweep write.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 0) addrA = 3'd7;
            if (c == 1) begin
                wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 8'h44; addrB = 3'd1;
            end
            @(negedge clk);
            if (c == 0) begin
                chk("sweep unswept addr7", Data_A, 8'hFF);
                chk("sweep unswept z addr7", zData_A, 8'hFF);
            end
            if (c == 1) begin
                chk("sweep no bypass addr1", Data_B, 8'hFF);
                chk("sweep no bypass z addr1", zData_B, 8'hFF);
            end
            if (!busy) break;
            chk($sformatf("sweep zbusy c%0d", c), {7'd0, zbusy}, 8'h01);
            busy_cnt++;
            $display("sweep cycle %0d: busy=%b", c, busy);
            tick();
            if (c == 1) idle_inputs();
        end
        chk("sweep busy length", 8'(busy_cnt), 8'd8);
        tick();
        check_all_zero("after sweep");

        // Second sweep interrupted by reset in its third cycle.
        wr0_en = 1'b1; wr0_addr = 3'd6; wr0_data = 8'hAA;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        addrA = 3'd6;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("sweep2 busy c%0d", c), {7'd0, busy}, 8'h01);
            chk($sformatf("sweep2 addr6 c%0d", c), Data_A, 8'hAA);
            $display("sweep2 cycle %0d: busy=%b A=%h", c, busy, Data_A);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset mid-sweep busy", {7'd0, busy}, 8'h00);
        chk("reset mid-sweep zbusy", {7'd0, zbusy}, 8'h00);
        $display("reset mid-sweep: busy=%b", busy);
        tick();
        check_all_zero("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
